log_fetch_engine: RTL and testbench

Bus-side read engine for the DFI log table. It services the DFI checker's log-read request (level request plus a byte address) by issuing three sequential 32-bit reads over an AXI4-Lite read channel to the 12-byte log entry. It returns the assembled 96-bit entry with a one-cycle done pulse. It sits between the DFI checker and the system interconnect: it consumes the checker's request/address pair and produces the checker's log-done/log-data inputs.

---
 rtl/log_fetch_engine.sv | 174 +++++++++++++++++
 tb/tb_log_fetch_engine.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/log_fetch_engine.sv
// Log-entry read engine: fetches a 12-byte log entry as three 32-bit AXI4-Lite reads
// and hands the assembled 96-bit entry back to the checker with a one-cycle done pulse.
module log_fetch_engine #(
   parameter int N_ADDR_WIDTH   = 32,
   parameter int N_DATA_WIDTH   = 32,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      i_rqAccess,
   input  logic [N_ADDR_WIDTH-1:0]   i_logAddr,
   output logic                      o_logDone,
   output logic [3*N_DATA_WIDTH-1:0] o_logData,
   output logic                      o_fetchErr,
   output logic                      o_busy,
   output logic [15:0]               o_fetchCount,
   output logic [N_ADDR_WIDTH-1:0]   o_araddr,
   output logic                      o_arvalid,
   input  logic                      i_arready,
   input  logic [N_DATA_WIDTH-1:0]   i_rdata,
   input  logic [1:0]                i_rresp,
   input  logic                      i_rvalid,
   output logic                      o_rready
);

   localparam int          EW       = 3 * N_DATA_WIDTH;
   localparam int          DW       = N_DATA_WIDTH;
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_DONE} state_t;

   state_t                  state_q, state_d;
   logic [N_ADDR_WIDTH-1:0] base_q, base_d;
   logic [1:0]              word_idx_q, word_idx_d;
   logic                    err_q, err_d;
   logic [EW-1:0]           entry_q, entry_d;
   logic [15:0]             tmo_q, tmo_d;
   logic [15:0]             fetch_count_q, fetch_count_d;
   logic [N_ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic                    arvalid_q, arvalid_d;
   logic                    rready_q, rready_d;
   logic                    done_q, done_d;
   logic                    busy_q, busy_d;
   logic                    tmo_expired;
   logic                    resp_err;
   logic [1:0]              next_idx;

   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      word_idx_d    = word_idx_q;
      err_d         = err_q;
      entry_d       = entry_q;
      tmo_d         = tmo_q;
      fetch_count_d = fetch_count_q;
      araddr_d      = araddr_q;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      done_d        = 1'b0;
      tmo_expired   = (tmo_q == TMO_LAST);
      resp_err      = (i_rresp inside {2'b10, 2'b11});
      next_idx      = word_idx_q + 2'd1;

      case (state_q)
         S_IDLE: begin
            if (i_rqAccess) begin
               if (i_logAddr[1:0] == 2'b00) begin
                  state_d    = S_ADDR;
                  base_d     = i_logAddr;
                  word_idx_d = 2'd0;
                  err_d      = 1'b0;
                  entry_d    = '0;
                  tmo_d      = '0;
                  araddr_d   = i_logAddr;
                  arvalid_d  = 1'b1;
               end else begin
                  // Misaligned entry: report the error without touching the bus.
                  state_d = S_DONE;
                  err_d   = 1'b1;
                  done_d  = 1'b1;
               end
            end
         end
         S_ADDR: begin
            if (i_arready) begin
               state_d  = S_DATA;
               tmo_d    = '0;
               rready_d = 1'b1;
            end else if (tmo_expired) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               done_d  = 1'b1;
            end else begin
               tmo_d     = tmo_q + 16'd1;
               arvalid_d = 1'b1;
            end
         end
         S_DATA: begin
            if (i_rvalid) begin
               case (word_idx_q)
                  2'd0:    entry_d[EW-1 -: DW]   = i_rdata;
                  2'd1:    entry_d[2*DW-1 -: DW] = i_rdata;
                  default: entry_d[DW-1:0]       = i_rdata;
               endcase
               err_d = err_q | resp_err;
               if (word_idx_q == 2'd2) begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d    = S_ADDR;
                  word_idx_d = next_idx;
                  tmo_d      = '0;
                  araddr_d   = base_q + {{(N_ADDR_WIDTH-4){1'b0}}, next_idx, 2'b00};
                  arvalid_d  = 1'b1;
               end
            end else if (tmo_expired) begin
               state_d = S_DONE;
               err_d   = 1'b1;
               done_d  = 1'b1;
            end else begin
               tmo_d    = tmo_q + 16'd1;
               rready_d = 1'b1;
            end
         end
         default: begin
            // Turnaround cycle: any request still held high is ignored here.
            state_d = S_IDLE;
            if (fetch_count_q != 16'hFFFF) fetch_count_d = fetch_count_q + 16'd1;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         base_q        <= '0;
         word_idx_q    <= '0;
         err_q         <= 1'b0;
         entry_q       <= '0;
         tmo_q         <= '0;
         fetch_count_q <= '0;
         araddr_q      <= '0;
         arvalid_q     <= 1'b0;
         rready_q      <= 1'b0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         base_q        <= base_d;
         word_idx_q    <= word_idx_d;
         err_q         <= err_d;
         entry_q       <= entry_d;
         tmo_q         <= tmo_d;
         fetch_count_q <= fetch_count_d;
         araddr_q      <= araddr_d;
         arvalid_q     <= arvalid_d;
         rready_q      <= rready_d;
         done_q        <= done_d;
         busy_q        <= busy_d;
      end
   end

   assign o_logDone    = done_q;
   assign o_logData    = entry_q;
   assign o_fetchErr   = err_q;
   assign o_busy       = busy_q;
   assign o_fetchCount = fetch_count_q;
   assign o_araddr     = araddr_q;
   assign o_arvalid    = arvalid_q;
   assign o_rready     = rready_q;

endmodule

// File: tb/tb_log_fetch_engine.sv
// Directed bench for log_fetch_engine: a vector table driven through a cycle-level
// AXI4-Lite slave model, plus reset, timeout and saturation sequences.
module tb_log_fetch_engine;

   logic        clk;
   logic        rst;
   logic        i_rqAccess;
   logic [31:0] i_logAddr;
   logic        o_logDone;
   logic [95:0] o_logData;
   logic        o_fetchErr;
   logic        o_busy;
   logic [15:0] o_fetchCount;
   logic [31:0] o_araddr;
   logic        o_arvalid;
   logic        i_arready;
   logic [31:0] i_rdata;
   logic [1:0]  i_rresp;
   logic        i_rvalid;
   logic        o_rready;

   int          n_checks;
   int          n_errors;
   logic [15:0] exp_count;

   log_fetch_engine #(
      .N_ADDR_WIDTH  (32),
      .N_DATA_WIDTH  (32),
      .TIMEOUT_CYCLES(8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_rqAccess  (i_rqAccess),
      .i_logAddr   (i_logAddr),
      .o_logDone   (o_logDone),
      .o_logData   (o_logData),
      .o_fetchErr  (o_fetchErr),
      .o_busy      (o_busy),
      .o_fetchCount(o_fetchCount),
      .o_araddr    (o_araddr),
      .o_arvalid   (o_arvalid),
      .i_arready   (i_arready),
      .i_rdata     (i_rdata),
      .i_rresp     (i_rresp),
      .i_rvalid    (i_rvalid),
      .o_rready    (o_rready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]      addr;
      logic [2:0][31:0] words;
      logic [2:0][1:0]  resp;
      logic [2:0][3:0]  ar_dly;
      logic [2:0][3:0]  r_dly;
      int               hang;      // word whose RVALID never comes, -1 for none
      int               drop_cyc;  // cycle at which the request is dropped, 0 for never
      int               exp_cyc;
      logic [95:0]      exp_data;
      logic             exp_err;
      bit               chk_data;
   } vec_t;

   vec_t vecs[9];

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [31:0] addr,
                               input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                               input logic [1:0] r0, input logic [1:0] r1, input logic [1:0] r2,
                               input logic [3:0] a0, input logic [3:0] a1, input logic [3:0] a2,
                               input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                               input int hang, input int drop, input int cyc,
                               input logic [95:0] data, input logic err, input bit chk);
      vec_t v;
      v.addr = addr;
      v.words[0] = w0;  v.words[1] = w1;  v.words[2] = w2;
      v.resp[0] = r0;   v.resp[1] = r1;   v.resp[2] = r2;
      v.ar_dly[0] = a0; v.ar_dly[1] = a1; v.ar_dly[2] = a2;
      v.r_dly[0] = d0;  v.r_dly[1] = d1;  v.r_dly[2] = d2;
      v.hang = hang; v.drop_cyc = drop; v.exp_cyc = cyc;
      v.exp_data = data; v.exp_err = err; v.chk_data = chk;
      return v;
   endfunction

   // Requests one entry and plays the slave cycle by cycle; inputs change and outputs
   // are sampled on the falling edge.
   task automatic run_vec(input vec_t v, input string tag);
      int          cyc;
      int          w;
      int          wait_cnt;
      int          done_cyc;
      bit          saw_ar;
      logic [31:0] exp_addr;
      logic [95:0] got_data;
      logic        got_err;
      @(negedge clk);
      i_rqAccess = 1'b1;
      i_logAddr  = v.addr;
      cyc = 0; w = 0; wait_cnt = 0; done_cyc = -1; saw_ar = 1'b0;
      got_data = '0; got_err = 1'b0;
      while (done_cyc < 0 && cyc < 60) begin
         @(negedge clk);
         cyc++;
         if (v.drop_cyc != 0 && cyc == v.drop_cyc) i_rqAccess = 1'b0;
         i_arready = 1'b0; i_rvalid = 1'b0; i_rresp = 2'b00; i_rdata = '0;
         if (o_logDone) begin
            done_cyc = cyc;
            got_data = o_logData;
            got_err  = o_fetchErr;
            check({tag, " busy_in_done"}, 96'(o_busy), 96'd1);
         end else if (o_arvalid) begin
            saw_ar   = 1'b1;
            exp_addr = v.addr + 32'(4 * w);
            check({tag, " araddr"}, 96'(o_araddr), 96'(exp_addr));
            if (wait_cnt == int'(v.ar_dly[w])) begin
               i_arready = 1'b1;
               wait_cnt  = 0;
            end else begin
               wait_cnt++;
            end
         end else if (o_rready) begin
            if (w != v.hang && wait_cnt == int'(v.r_dly[w])) begin
               i_rvalid = 1'b1;
               i_rdata  = v.words[w];
               i_rresp  = v.resp[w];
               wait_cnt = 0;
               w++;
            end else begin
               wait_cnt++;
            end
         end
      end
      i_rqAccess = 1'b0;
      i_arready = 1'b0; i_rvalid = 1'b0; i_rresp = 2'b00; i_rdata = '0;
      check({tag, " done_seen"}, 96'(done_cyc >= 0), 96'd1);
      check({tag, " done_cycle"}, 96'(done_cyc), 96'(v.exp_cyc));
      check({tag, " arvalid_seen"}, 96'(saw_ar), 96'(v.addr[1:0] == 2'b00));
      check({tag, " fetch_err"}, 96'(got_err), 96'(v.exp_err));
      if (v.chk_data) check({tag, " log_data"}, got_data, v.exp_data);
      if (exp_count != 16'hFFFF) exp_count = exp_count + 16'd1;
      @(negedge clk);
      check({tag, " done_pulse"}, 96'(o_logDone), 96'd0);
      check({tag, " busy_idle"}, 96'(o_busy), 96'd0);
      check({tag, " fetch_count"}, 96'(o_fetchCount), 96'(exp_count));
      check({tag, " err_held"}, 96'(o_fetchErr), 96'(v.exp_err));
      if (v.chk_data) check({tag, " data_held"}, o_logData, v.exp_data);
   endtask

   initial begin
      int cnt;
      n_checks = 0; n_errors = 0; exp_count = 16'd0;
      rst = 1'b0; i_rqAccess = 1'b0; i_logAddr = '0;
      i_arready = 1'b0; i_rdata = '0; i_rresp = 2'b00; i_rvalid = 1'b0;

      //        addr          w0            w1            w2            r0     r1     r2     ar dly          r dly           hang drop cyc data                              err   chk
      vecs[0] = mk(32'h1FEFF800, 32'h03000000, 32'h00000024, 32'h00000050, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0,  4'd0, 4'd0, 4'd0, -1, 0,  7, 96'h030000000000002400000050, 1'b0, 1'b1);
      vecs[1] = mk(32'h00001000, 32'h11111111, 32'h22222222, 32'h33333333, 2'b00, 2'b00, 2'b00, 4'd0, 4'd3, 4'd0,  4'd0, 4'd0, 4'd2, -1, 0, 12, 96'h111111112222222233333333, 1'b0, 1'b1);
      vecs[2] = mk(32'h00002000, 32'hDEAD0001, 32'hBAD00002, 32'h00C0FFEE, 2'b00, 2'b10, 2'b00, 4'd0, 4'd0, 4'd0,  4'd0, 4'd0, 4'd0, -1, 0,  7, 96'hDEAD0001BAD0000200C0FFEE, 1'b1, 1'b1);
      vecs[3] = mk(32'h00003000, 32'h12345678, 32'h9ABCDEF0, 32'h0F0F0F0F, 2'b00, 2'b00, 2'b01, 4'd0, 4'd0, 4'd0,  4'd0, 4'd0, 4'd0, -1, 0,  7, 96'h123456789ABCDEF00F0F0F0F, 1'b0, 1'b1);
      vecs[4] = mk(32'h00004000, 32'h55555555, 32'h66666666, 32'h77777777, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0,  4'd0, 4'd0, 4'd0,  0, 0, 10, 96'h0,                          1'b1, 1'b1);
      vecs[5] = mk(32'h1FEFF802, 32'h0,        32'h0,        32'h0,        2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0,  4'd0, 4'd0, 4'd0, -1, 0,  1, 96'h0,                          1'b1, 1'b0);
      vecs[6] = mk(32'hFFFFFFF8, 32'h00000001, 32'h00000002, 32'h00000003, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0,  4'd0, 4'd0, 4'd0, -1, 0,  7, 96'h000000010000000200000003, 1'b0, 1'b1);
      vecs[7] = mk(32'h00005000, 32'hAAAA0000, 32'hBBBB0000, 32'hCCCC0000, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 4'd15, 4'd0, 4'd0, 4'd0, -1, 0, 13, 96'hAAAA0000BBBB000000000000, 1'b1, 1'b1);
      vecs[8] = mk(32'h00000040, 32'h00000005, 32'h00000006, 32'h00000007, 2'b00, 2'b00, 2'b00, 4'd0, 4'd0, 4'd0,  4'd0, 4'd0, 4'd0, -1, 2,  7, 96'h000000050000000600000007, 1'b0, 1'b1);

      #1;
      check("rst done",    96'(o_logDone),    96'd0);
      check("rst data",    o_logData,         96'd0);
      check("rst err",     96'(o_fetchErr),   96'd0);
      check("rst busy",    96'(o_busy),       96'd0);
      check("rst count",   96'(o_fetchCount), 96'd0);
      check("rst araddr",  96'(o_araddr),     96'd0);
      check("rst arvalid", 96'(o_arvalid),    96'd0);
      check("rst rready",  96'(o_rready),     96'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 9; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

      // Reset while waiting for read data.
      @(negedge clk);
      i_rqAccess = 1'b1;
      i_logAddr  = 32'h00000100;
      cnt = 0;
      while (!o_rready && cnt < 20) begin
         @(negedge clk);
         cnt++;
         i_arready = o_arvalid;
      end
      i_arready = 1'b0;
      check("mid reach_data", 96'(o_rready), 96'd1);
      #2 rst = 1'b0;
      #1;
      check("mid arvalid", 96'(o_arvalid),    96'd0);
      check("mid rready",  96'(o_rready),     96'd0);
      check("mid busy",    96'(o_busy),       96'd0);
      check("mid count",   96'(o_fetchCount), 96'd0);
      check("mid done",    96'(o_logDone),    96'd0);
      i_rqAccess = 1'b0;
      exp_count  = 16'd0;
      @(negedge clk);
      rst = 1'b1;
      run_vec(vecs[0], "post_rst");

      // Counter saturation: preload just below the ceiling, then keep fetching.
      @(negedge clk);
      force dut.fetch_count_q = 16'hFFFE;
      #1 release dut.fetch_count_q;
      exp_count = 16'hFFFE;
      run_vec(vecs[5], "sat1");
      run_vec(vecs[0], "sat2");
      run_vec(vecs[5], "sat3");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
